// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Parses framed host commands from the UART byte stream and drives operand
//   memory writes and the compute start pulse.
//   Frame: 0xA5, CMD, LEN, LEN payload bytes, CHK  (CHK = CMD+LEN+payload mod 256)
//   CMD 0x01 -> load memory A, 0x02 -> load memory B (1 <= LEN <= DEPTH),
//   CMD 0x03 -> compute start (LEN must be 0).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   rx_data/valid     : received byte and its one-cycle strobe
//   rx_error          : one-cycle UART framing error strobe
//   mem_we/sel/addr/wdata : registered operand memory write port
//   start             : one-cycle compute start pulse
//   frame_done/err    : one-cycle frame accepted / aborted pulses
//   err_code          : code of most recent abort (1 rx err, 2 cmd, 3 len, 4 chk, 5 timeout)
//   busy              : high whenever a frame is in progress
module uart_frame_loader #(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  start,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [2:0]            err_code,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t                state, state_nx;
    logic                  cmd_start;      // current frame is a compute-start command
    logic [7:0]            cnt;            // payload bytes still expected
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            chk_acc;
    logic [TW-1:0]         tcnt;

    logic                  accept;         // a byte that survives error arbitration
    logic                  len_ok;
    logic                  timeout;
    logic                  abort;
    logic [2:0]            abort_code;
    logic                  we_nx, done_nx, start_nx;

    assign accept  = rx_valid && !rx_error;
    assign len_ok  = cmd_start ? (rx_data == 8'd0)
                               : (rx_data != 8'd0) && ({1'b0, rx_data} <= 9'(DEPTH));
    // tcnt holds the number of silent cycles already elapsed; this cycle is the last allowed
    assign timeout = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; priority is rx_error, then a valid byte, then timeout
    always_comb begin
        state_nx   = state;
        abort      = 1'b0;
        abort_code = 3'd0;
        if (state != S_IDLE && rx_error) begin
            abort      = 1'b1;
            abort_code = 3'd1;
        end else if (rx_valid) begin
            unique case (state)
                S_IDLE:    if (rx_data == 8'hA5) state_nx = S_CMD;
                S_CMD: begin
                    if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03)
                        state_nx = S_LEN;
                    else begin
                        abort      = 1'b1;
                        abort_code = 3'd2;
                    end
                end
                S_LEN: begin
                    if (!len_ok) begin
                        abort      = 1'b1;
                        abort_code = 3'd3;
                    end else if (rx_data == 8'd0) state_nx = S_CHK;
                    else                          state_nx = S_PAYLOAD;
                end
                S_PAYLOAD: if (cnt == 8'd1) state_nx = S_CHK;
                S_CHK: begin
                    state_nx = S_IDLE;
                    if (rx_data != chk_acc) begin
                        abort      = 1'b1;
                        abort_code = 3'd4;
                    end
                end
                default:   state_nx = S_IDLE;
            endcase
        end else if (timeout) begin
            abort      = 1'b1;
            abort_code = 3'd5;
        end
        if (abort) state_nx = S_IDLE;
    end

    // Output decode (registered below so pulses land in the cycle after the byte)
    always_comb begin
        we_nx    = accept && (state == S_PAYLOAD);
        done_nx  = accept && (state == S_CHK) && (rx_data == chk_acc);
        start_nx = done_nx && cmd_start;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 3'd0;
            cmd_start  <= 1'b0;
            cnt        <= 8'd0;
            wr_addr    <= '0;
            chk_acc    <= 8'd0;
            tcnt       <= '0;
        end else begin
            mem_we     <= we_nx;
            mem_addr   <= we_nx ? wr_addr : '0;
            mem_wdata  <= we_nx ? rx_data : 8'd0;
            start      <= start_nx;
            frame_done <= done_nx;
            frame_err  <= abort;
            if (abort) err_code <= abort_code;

            if (state == S_IDLE || rx_valid) tcnt <= '0;
            else                             tcnt <= tcnt + 1'b1;

            if (accept) begin
                unique case (state)
                    S_IDLE: if (rx_data == 8'hA5) chk_acc <= 8'd0;
                    S_CMD: begin
                        chk_acc   <= chk_acc + rx_data;
                        cmd_start <= (rx_data == 8'h03);
                        if (rx_data == 8'h01 || rx_data == 8'h02) mem_sel <= rx_data[1];
                    end
                    S_LEN: begin
                        chk_acc <= chk_acc + rx_data;
                        cnt     <= rx_data;
                        wr_addr <= '0;
                    end
                    S_PAYLOAD: begin
                        chk_acc <= chk_acc + rx_data;
                        cnt     <= cnt - 8'd1;
                        wr_addr <= wr_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed self-checking bench for uart_frame_loader (ADDR_WIDTH 4, TIMEOUT_CYCLES 20).
module tb_uart_frame_loader;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid, rx_error;
    logic       mem_we, mem_sel, start, frame_done, frame_err, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [2:0] err_code;

    int tests = 0, fails = 0;

    // event log filled on the falling edge
    int          n_we = 0, n_done = 0, n_err = 0, n_start = 0, n_sd = 0;
    logic [12:0] wr_log [0:63];
    int          b_we, b_done, b_err, b_start, b_sd;

    uart_frame_loader #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .start(start), .frame_done(frame_done),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_log[n_we & 63] <= {mem_sel, mem_addr, mem_wdata};
            n_we <= n_we + 1;
        end
        if (frame_done)          n_done  <= n_done + 1;
        if (frame_err)           n_err   <= n_err + 1;
        if (start)               n_start <= n_start + 1;
        if (start && frame_done) n_sd    <= n_sd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_we = n_we; b_done = n_done; b_err = n_err; b_start = n_start; b_sd = n_sd;
    endtask

    // returns 1 ns into the cycle after the byte was sampled
    task automatic send(input logic [7:0] b);
        repeat (2) @(posedge clk);
        #1 rx_data = b; rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_all(input byte_q_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic deltas(input string tag, input int we, input int done, input int err, input int st);
        check({tag, "_we"},    n_we - b_we,       we);
        check({tag, "_done"},  n_done - b_done,   done);
        check({tag, "_err"},   n_err - b_err,     err);
        check({tag, "_start"}, n_start - b_start, st);
    endtask

    initial begin
        int wait_n;
        rx_data = 8'd0; rx_valid = 1'b0; rx_error = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_outs", {mem_we, mem_sel, mem_addr, mem_wdata, start, frame_done,
                             frame_err, err_code, busy}, 0);

        // Load A, two bytes
        snap();
        send(8'hA5);
        check("busy_after_sync", busy, 1);
        send_all('{8'h01, 8'h02, 8'h10});
        check("loadA_w0_now", {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'd0, 8'h10});
        send(8'h20);
        send(8'h33);
        check("loadA_done_now", {frame_done, busy}, 2'b10);
        settle();
        deltas("loadA", 2, 1, 0, 0);
        check("loadA_w0", wr_log[b_we & 63],       13'h0010);
        check("loadA_w1", wr_log[(b_we + 1) & 63], 13'h0120);
        check("loadA_code", err_code, 0);

        // Bad checksum into B
        snap();
        send_all('{8'hA5, 8'h02, 8'h01, 8'hFF, 8'h00});
        check("badchk_now", {frame_err, err_code, busy}, {1'b1, 3'd4, 1'b0});
        settle();
        deltas("badchk", 1, 0, 1, 0);
        check("badchk_w0", wr_log[b_we & 63], {1'b1, 4'd0, 8'hFF});

        // Start command, preceded by noise in IDLE
        snap();
        send_all('{8'h12, 8'h34});
        check("noise_idle", busy, 0);
        send_all('{8'hA5, 8'h03, 8'h00, 8'h03});
        check("start_now", {start, frame_done}, 2'b11);
        settle();
        deltas("start", 0, 1, 0, 1);
        check("start_same", n_sd - b_sd, 1);

        // Length / command errors
        snap();
        send_all('{8'hA5, 8'h01, 8'h11});
        check("len_big_code", err_code, 3);
        settle();
        deltas("len_big", 0, 0, 1, 0);
        snap();
        send_all('{8'hA5, 8'h03, 8'h01});
        check("len_st_now", {frame_err, err_code}, {1'b1, 3'd3});
        settle();
        deltas("len_st", 0, 0, 1, 0);
        snap();
        send_all('{8'hA5, 8'h07});
        check("cmd_bad_code", err_code, 2);
        settle();
        deltas("cmd_bad", 0, 0, 1, 0);

        // LEN = DEPTH: last write lands on address 15
        snap();
        send_all('{8'hA5, 8'h01, 8'h10});
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h89);
        settle();
        deltas("full", 16, 1, 0, 0);
        check("full_last", wr_log[(b_we + 15) & 63], {1'b0, 4'd15, 8'h0F});

        // Timeout after A5 01
        snap();
        send_all('{8'hA5, 8'h01});
        wait_n = 31;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                wait_n = i;
                break;
            end
        end
        check("to_lat_ok", (wait_n >= 20 && wait_n <= 22), 1);
        check("to_code_busy", {err_code, busy}, {3'd5, 1'b0});
        settle();
        deltas("to", 0, 0, 1, 0);
        snap();
        send_all('{8'hA5, 8'h02, 8'h01, 8'h55, 8'h58});
        settle();
        deltas("after_to", 1, 1, 0, 0);
        check("after_to_w", wr_log[b_we & 63], {1'b1, 4'd0, 8'h55});

        // Framing error mid-payload
        snap();
        send_all('{8'hA5, 8'h01, 8'h03, 8'hAA});
        @(posedge clk);
        #1 rx_error = 1'b1;
        @(posedge clk);
        #1 rx_error = 1'b0;
        check("rxerr_now", {frame_err, err_code, busy}, {1'b1, 3'd1, 1'b0});
        settle();
        deltas("rxerr", 1, 0, 1, 0);

        // Asynchronous reset mid-payload, while a write pulse is showing
        send_all('{8'hA5, 8'h01, 8'h03, 8'hBB});
        #2 reset = 1'b1;
        #1;
        check("rst_async", {mem_we, mem_sel, mem_addr, mem_wdata, start, frame_done,
                            frame_err, err_code, busy}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        snap();
        send_all('{8'hCC, 8'hDD, 8'h00});
        settle();
        deltas("post_rst", 0, 0, 0, 0);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Byte-stream frame parser and load controller between the UART receiver and the systolic array operand memories. Consumes received bytes and their error strobe, validates framed commands, writes payload bytes into operand memory A or B, and issues a single-cycle compute start. It is the only writer of operand memory during host load and the only source of the array start pulse.

## Interface

**Parameters**
- `ADDR_WIDTH`, 4: operand memory address width. Memory depth is `DEPTH = 2**ADDR_WIDTH`. `ADDR_WIDTH` must be 8 or less.
- `TIMEOUT_CYCLES`, 50_000_000: number of idle clock cycles allowed between bytes inside a frame before the frame is aborted.

**Ports**
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte. Sampled only when `rx_valid` is high.
- `rx_valid`, in, 1: one-cycle strobe; one byte received.
- `rx_error`, in, 1: one-cycle strobe; UART framing error.
- `mem_we`, out, 1: operand memory write enable; one-cycle pulse per payload byte.
- `mem_sel`, out, 1: target memory, 0 = A, 1 = B. Stable for the whole frame.
- `mem_addr`, out, ADDR_WIDTH: write address.
- `mem_wdata`, out, 8: write data.
- `start`, out, 1: one-cycle compute start pulse.
- `frame_done`, out, 1: one-cycle pulse; frame accepted.
- `frame_err`, out, 1: one-cycle pulse; frame aborted.
- `err_code`, out, 3: code of the most recent error; held until the next error.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation

**Frame format:** `0xA5`, CMD, LEN, LEN payload bytes, CHK.
- CHK = (CMD + LEN + all payload bytes) mod 256.
- CMD `0x01` loads memory A. CMD `0x02` loads memory B. Both require 1 ≤ LEN ≤ DEPTH.
- CMD `0x03` starts a compute. It requires LEN = 0.

**States and transitions:** IDLE, CMD, LEN, PAYLOAD, CHK.
- IDLE: a byte equal to `0xA5` moves to CMD. Any other byte is ignored. `rx_error` is ignored in IDLE.
- CMD: byte `0x01` or `0x02` sets `mem_sel` and goes to LEN. Byte `0x03` goes to LEN. Any other value aborts with code 2.
- LEN: an illegal LEN for the command aborts with code 3. LEN = 0 goes to CHK. Otherwise go to PAYLOAD, with the remaining count set to LEN and the address set to 0.
- PAYLOAD: each byte writes to the current address, then the address increments. After the LEN-th byte, go to CHK.
- CHK: a matching CHK pulses `frame_done`; for CMD `0x03` it also pulses `start`. A mismatch aborts with code 4. In both cases, return to IDLE.

**Aborts and errors:**
- `rx_error` in any non-IDLE state aborts with code 1.
- Timeout aborts with code 5.
- Every abort pulses `frame_err`, updates `err_code`, and returns to IDLE.
- Payload writes are not rolled back on abort or checksum failure. Downstream logic treats memory contents as valid only after `frame_done`.

**Timeout counter:**
- Counts only outside IDLE.
- Clears on each `rx_valid` and on entry to IDLE.
- Reaching TIMEOUT_CYCLES consecutive cycles with no `rx_valid` triggers the timeout abort.

**Arbitration:**
- If `rx_valid` and `rx_error` are high in the same cycle, the error wins and the byte is discarded.
- If the timeout expires in the same cycle as `rx_valid`, the byte wins and the counter clears.

**Checksum accumulator:** 8-bit, wrapping. Cleared on sync acceptance; accumulates CMD, LEN and each payload byte.

## Timing

**Reset:** asynchronous reset drives the state to IDLE and every output to 0, including `err_code` = 0 and `mem_sel` = 0. Reset asserted mid-frame discards the frame with no pulse.

**Latency (N = cycle in which `rx_valid` is sampled):**
- Payload byte at cycle N: `mem_we`, `mem_addr` and `mem_wdata` are registered and high/valid in cycle N+1 only.
- CHK byte at cycle N: `frame_done` (and `start` for CMD `0x03`) pulse in cycle N+1.
- Bad-byte abort at cycle N: `frame_err` and the new `err_code` appear in cycle N+1.
- Timeout abort: `frame_err` appears in the cycle after expiry.

**busy:** rises the cycle after the sync byte is sampled. Falls in the same cycle as the `frame_done` or `frame_err` pulse.

**Back-to-back frames:** a sync byte sampled in the cycle immediately after a frame ends is accepted. `rx_valid` spacing is at least one UART character time, so no input buffering is required.

**Address wrap:** the address never wraps within a legal frame. The final write of a LEN = DEPTH frame uses address DEPTH-1.

## Test plan

- **Load A:** bytes A5 01 02 10 20 33 → writes (sel 0, addr 0, 0x10) then (addr 1, 0x20); `frame_done` pulses once; `err_code` stays 0.
- **Bad checksum:** A5 02 01 FF 00 → one write (sel 1, addr 0, 0xFF); `frame_err` pulses with `err_code` = 4; no `frame_done`.
- **Start:** A5 03 00 03 → `start` and `frame_done` pulse in the same cycle; `mem_we` never asserts. Bytes 12 34 sent beforehand are ignored in IDLE.
- **Length and command errors:** A5 01 11 (DEPTH = 16) → `err_code` = 3. A5 03 01 → `err_code` = 3. A5 07 → `err_code` = 2. Each produces one `frame_err` pulse and no writes.
- **Timeout (`TIMEOUT_CYCLES` = 20):** A5 01 then silence → `frame_err` with `err_code` = 5 within 22 cycles of the last byte; `busy` falls. A following valid frame is accepted normally.
- **Framing error and reset:** `rx_error` strobed mid-payload → `err_code` = 1. `reset` asserted mid-payload (asynchronously, between clock edges) → all outputs 0 immediately, and no pulses afterward.
